multicycle_core: RTL and testbench
==================================

# multicycle_core

Parametrised successor to the RV32I multicycle datapath. It combines the datapath and its control state machine in one block and adds a synchronous active-low reset. Memory is reached through a variable-latency req/ready handshake in place of a fixed single-cycle memory. The block also adds trap and halt detection, a retired-instruction counter and a selectable debug register port. It sits between the board top level and an external unified instruction/data memory, and reuses the existing `Registers`, `ImmediateGenerator`, `ALU` and `ALUControl` blocks.

## Interface
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- HALT_ON_ECALL, 1, 1: ECALL enters HALT. 0: ECALL is treated as NOP.
- CHECK_ALIGN, 1, 1: misaligned LW/SW address or jump/branch target enters TRAP.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low.
- `memReq` out 1: memory transaction request.
- `memWrite` out 1: 1 = write, 0 = read. Meaningful only while `memReq`=1.
- `memAddress` out 32: byte address, word-aligned.
- `memWriteData` out 32: store data (rs2).
- `memReady` in 1: transaction completes in the cycle where `memReq` and `memReady` are both 1.
- `memReadData` in 32: read data, valid in the completing cycle only.
- `halted` out 1: sticky; core is in HALT.
- `trap` out 1: sticky; core is in TRAP.
- `instret` out 32: retired-instruction count, wraps modulo 2^32.
- `dWatchSel` in 5: debug register index.
- `dRegister` out 32: value of x[`dWatchSel`], combinational; x0 reads 0.
- `dInstruction` out 32: instruction register.
- `dPC` out 32: PC.
- `dState` out 4: current state encoding.

## Operation
- States and encodings: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_READ=5, MEM_WRITE=6, WB_ALU=7, WB_MEM=8, BRANCH=9, JAL=10, JALR=11, UPPER=12, HALT=14, TRAP=15.
- FETCH
  - Drives `memReq`=1, `memWrite`=0, `memAddress`=PC.
  - Stays in FETCH until `memReady`=1.
  - On completion: IR<=`memReadData`, CurrentPC<=PC, PC<=PC+4, next state DECODE.
- DECODE
  - Latches A<=x[rs1], B<=x[rs2].
  - Dispatches by opcode:
    - OP goes to EXEC_R; OP-IMM goes to EXEC_I.
    - LOAD and STORE go to MEM_ADDR.
    - BRANCH goes to BRANCH; JAL goes to JAL; JALR goes to JALR.
    - LUI and AUIPC go to UPPER.
    - SYSTEM with IR=32'h0000_0073 goes to HALT (or FETCH with a retire when HALT_ON_ECALL=0).
    - Any other opcode goes to TRAP.
- EXEC_R / EXEC_I: ALUReg<=A op B (or A op imm), then WB_ALU.
- WB_ALU: x[rd]<=ALUReg, retire, then FETCH.
- MEM_ADDR
  - ALUReg<=A+imm.
  - If CHECK_ALIGN and the sum's [1:0]≠0, go to TRAP.
  - Otherwise LOAD goes to MEM_READ and STORE goes to MEM_WRITE.
- MEM_READ: `memReq`=1, `memAddress`=ALUReg. Holds until `memReady`; then DataReg<=`memReadData` and go to WB_MEM.
- WB_MEM: x[rd]<=DataReg, retire, then FETCH.
- MEM_WRITE: `memReq`=1, `memWrite`=1, `memWriteData`=B. Holds until `memReady`; then retire and go to FETCH.
- BRANCH
  - Condition is one of BEQ/BNE/BLT/BGE/BLTU/BGEU, per funct3.
  - Taken: PC<=CurrentPC+imm. Not taken: PC unchanged.
  - Retire, then FETCH.
  - Misaligned taken target with CHECK_ALIGN=1 goes to TRAP instead, PC unchanged.
- JAL: x[rd]<=CurrentPC+4, PC<=CurrentPC+imm, retire, then FETCH.
- JALR: x[rd]<=CurrentPC+4, PC<=(A+imm)&~1, retire, then FETCH. Alignment is checked on the target.
- UPPER: x[rd]<=imm (LUI) or CurrentPC+imm (AUIPC), retire, then FETCH.
- HALT and TRAP
  - Absorbing: only `reset` exits them.
  - `memReq`=0.
  - Set `halted` or `trap` respectively.
- Writes to x0 are discarded.
- Funct3 values not defined for BRANCH, LOAD (≠010) or STORE (≠010) go to TRAP from DECODE.
- Retire means `instret`<=`instret`+1 on that same edge.

## Timing
- Reset
  - Sampled with `reset`=0 at a rising edge: state=FETCH, PC=RESET_PC, IR=0, `instret`=0, `halted`=0, `trap`=0. Register file contents are unchanged.
  - `memReq` is forced to 0 whenever `reset`=0.
  - First fetch request appears in the first cycle with `reset`=1.
- Reset during an outstanding transaction: the request is dropped and `memReady`/`memReadData` in that cycle are ignored.
- Handshake
  - `memAddress`, `memWrite` and `memWriteData` are held stable while `memReq`=1 and `memReady`=0.
  - `memReady` asserted in the same cycle as `memReq` is a zero-wait completion.
  - `memReady` while `memReq`=0 is ignored.
- Cycle counts at zero wait states:
  - R/I-type: 4 (FETCH, DECODE, EXEC, WB).
  - Load: 5. Store: 4.
  - Branch, JAL, JALR, LUI, AUIPC: 3.
  - Each wait cycle adds 1 to FETCH or to the MEM state.
- STORE→FETCH is back-to-back: `memReq` stays 1 and address/write change at the completion edge.
- Arithmetic is 32-bit modulo. PC wraps from 32'hFFFF_FFFC to 0.

## Test plan
- Reset with `memReady` tied 1, memory `addi x1,x0,5; addi x2,x1,-7; ecall` -> x1=5, x2=32'hFFFF_FFFE, `halted`=1, `instret`=2, 10 cycles from reset release to HALT.
- `sw x1,8(x0); lw x3,8(x0)` with `memReady` delayed 3 cycles per request -> store `memAddress`=8, `memWriteData`=5; x3=5; signals stable during waits; load takes 5+6 cycles.
- `beq x0,x0,-4` loop and `bne x0,x0,8` -> taken PC=CurrentPC-4; not-taken PC=CurrentPC+4; 3 cycles each.
- `jal x1,16` at RESET_PC -> x1=32'h0040_0004, PC=32'h0040_0010. `jalr x0,3(x1)` with CHECK_ALIGN=1 -> `trap`=1, PC unchanged.
- Illegal word 32'hFFFF_FFFF, and `lw x4,2(x0)` -> each reaches TRAP, `instret` unchanged, `memReq` stays 0.
- Assert `reset`=0 during a FETCH wait -> `memReq`=0 next cycle, PC=RESET_PC, `instret`=0, execution restarts cleanly.

Source files
------------

// File: rtl/multicycle_core_if.sv
// Memory port of multicycle_core: unified instruction/data memory with a
// variable-latency req/ready handshake.
interface multicycle_core_if;
    localparam int unsigned XLEN = 32;

    logic            memReq;
    logic            memWrite;
    logic [XLEN-1:0] memAddress;
    logic [XLEN-1:0] memWriteData;
    logic            memReady;
    logic [XLEN-1:0] memReadData;

    modport master (
        output memReq, memWrite, memAddress, memWriteData,
        input  memReady, memReadData
    );

    modport slave (
        input  memReq, memWrite, memAddress, memWriteData,
        output memReady, memReadData
    );
endinterface

// File: rtl/multicycle_core.sv
// RV32I multicycle core: datapath, register file and control FSM in one block,
// with trap/halt detection, retired-instruction counter and a debug port.
module multicycle_core #(
    parameter logic [31:0] RESET_PC      = 32'h0040_0000,
    parameter bit          HALT_ON_ECALL = 1'b1,
    parameter bit          CHECK_ALIGN   = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    multicycle_core_if.master mem,
    output logic              halted,
    output logic              trap,
    output logic [31:0]       instret,
    input  logic [4:0]        dWatchSel,
    output logic [31:0]       dRegister,
    output logic [31:0]       dInstruction,
    output logic [31:0]       dPC,
    output logic [3:0]        dState
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,  S_DECODE  = 4'd1,  S_EXEC_R    = 4'd2,  S_EXEC_I = 4'd3,
        S_MEM_ADDR = 4'd4,  S_MEM_READ = 4'd5, S_MEM_WRITE = 4'd6,  S_WB_ALU = 4'd7,
        S_WB_MEM   = 4'd8,  S_BRANCH  = 4'd9,  S_JAL       = 4'd10, S_JALR   = 4'd11,
        S_UPPER    = 4'd12, S_HALT    = 4'd14, S_TRAP      = 4'd15
    } state_e;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, cur_pc_q, cur_pc_d, ir_q, ir_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, alu_q, alu_d, data_q, data_d;
    logic [XLEN-1:0] instret_q, instret_d;
    logic            halted_q, halted_d, trap_q, trap_d;
    logic [XLEN-1:0] regs_q [NREG];

    logic            retire, rf_we, req_c, wr_c;
    logic [XLEN-1:0] rf_wdata, addr_c;

    logic [6:0]      opcode;
    logic [4:0]      rd, rs1, rs2;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, rs1_val, rs2_val;
    logic [XLEN-1:0] br_target, jal_target, jalr_target, mem_ea, link;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];

    assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_u = {ir_q[31:12], 12'b0};
    assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

    assign rs1_val   = (rs1 == 5'd0) ? '0 : regs_q[rs1];
    assign rs2_val   = (rs2 == 5'd0) ? '0 : regs_q[rs2];
    assign dRegister = (dWatchSel == 5'd0) ? '0 : regs_q[dWatchSel];

    assign br_target   = cur_pc_q + imm_b;
    assign jal_target  = cur_pc_q + imm_j;
    assign jalr_target = (a_q + imm_i) & ~32'd1;
    assign mem_ea      = a_q + ((opcode == OP_STORE) ? imm_s : imm_i);
    assign link        = cur_pc_q + 32'd4;

    function automatic logic misaligned(input logic [XLEN-1:0] x);
        return CHECK_ALIGN && (x[1:0] != 2'b00);
    endfunction

    function automatic logic [XLEN-1:0] alu_op(input logic [2:0] f3, input logic alt,
                                               input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
        logic [XLEN-1:0] r;
        case (f3)
            3'b000:  r = alt ? x - y : x + y;
            3'b001:  r = x << y[4:0];
            3'b010:  r = XLEN'($signed(x) < $signed(y));
            3'b011:  r = XLEN'(x < y);
            3'b100:  r = x ^ y;
            3'b101:  r = alt ? XLEN'($signed(x) >>> y[4:0]) : (x >> y[4:0]);
            3'b110:  r = x | y;
            default: r = x & y;
        endcase
        return r;
    endfunction

    function automatic logic br_taken(input logic [2:0] f3, input logic [XLEN-1:0] x,
                                      input logic [XLEN-1:0] y);
        logic t;
        case (f3)
            3'b000:  t = (x == y);
            3'b001:  t = (x != y);
            3'b100:  t = ($signed(x) < $signed(y));
            3'b101:  t = ($signed(x) >= $signed(y));
            3'b110:  t = (x < y);
            default: t = (x >= y);
        endcase
        return t;
    endfunction

    // Next-state, datapath updates and memory request
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cur_pc_d = cur_pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        alu_d    = alu_q;
        data_d   = data_q;
        retire   = 1'b0;
        rf_we    = 1'b0;
        rf_wdata = alu_q;
        req_c    = 1'b0;
        wr_c     = 1'b0;
        addr_c   = pc_q;

        case (state_q)
            S_FETCH: begin
                req_c = 1'b1;
                if (mem.memReady) begin
                    ir_d     = mem.memReadData;
                    cur_pc_d = pc_q;
                    pc_d     = pc_q + 32'd4;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d = rs1_val;
                b_d = rs2_val;
                case (opcode)
                    OP_OP:             state_d = S_EXEC_R;
                    OP_IMM:            state_d = S_EXEC_I;
                    OP_LOAD, OP_STORE: state_d = (funct3 == 3'b010) ? S_MEM_ADDR : S_TRAP;
                    OP_BRANCH:         state_d = (funct3[2:1] == 2'b01) ? S_TRAP : S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI, OP_AUIPC:  state_d = S_UPPER;
                    OP_SYSTEM: begin
                        if (ir_q != 32'h0000_0073) begin
                            state_d = S_TRAP;
                        end else if (HALT_ON_ECALL) begin
                            state_d = S_HALT;
                        end else begin
                            retire  = 1'b1;
                            state_d = S_FETCH;
                        end
                    end
                    default:           state_d = S_TRAP;
                endcase
            end
            S_EXEC_R: begin
                alu_d   = alu_op(funct3, ir_q[30], a_q, b_q);
                state_d = S_WB_ALU;
            end
            S_EXEC_I: begin
                alu_d   = alu_op(funct3, (funct3 == 3'b101) && ir_q[30], a_q, imm_i);
                state_d = S_WB_ALU;
            end
            S_WB_ALU: begin
                rf_we   = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_d = mem_ea;
                if (misaligned(mem_ea))       state_d = S_TRAP;
                else if (opcode == OP_LOAD)   state_d = S_MEM_READ;
                else                          state_d = S_MEM_WRITE;
            end
            S_MEM_READ: begin
                req_c  = 1'b1;
                addr_c = alu_q;
                if (mem.memReady) begin
                    data_d  = mem.memReadData;
                    state_d = S_WB_MEM;
                end
            end
            S_WB_MEM: begin
                rf_we    = 1'b1;
                rf_wdata = data_q;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEM_WRITE: begin
                req_c  = 1'b1;
                wr_c   = 1'b1;
                addr_c = alu_q;
                if (mem.memReady) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_BRANCH: begin
                if (br_taken(funct3, a_q, b_q) && misaligned(br_target)) begin
                    state_d = S_TRAP;
                end else begin
                    if (br_taken(funct3, a_q, b_q)) pc_d = br_target;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_JAL, S_JALR: begin
                if (misaligned((state_q == S_JAL) ? jal_target : jalr_target)) begin
                    state_d = S_TRAP;
                end else begin
                    rf_we    = 1'b1;
                    rf_wdata = link;
                    pc_d     = (state_q == S_JAL) ? jal_target : jalr_target;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_UPPER: begin
                rf_we    = 1'b1;
                rf_wdata = (opcode == OP_LUI) ? imm_u : cur_pc_q + imm_u;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_HALT, S_TRAP: state_d = state_q;
            default:        state_d = S_TRAP;
        endcase
    end

    assign instret_d = retire ? instret_q + 32'd1 : instret_q;
    assign halted_d  = halted_q | (state_d == S_HALT);
    assign trap_d    = trap_q | (state_d == S_TRAP);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            cur_pc_q  <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_q     <= '0;
            data_q    <= '0;
            instret_q <= '0;
            halted_q  <= 1'b0;
            trap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cur_pc_q  <= cur_pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_q     <= alu_d;
            data_q    <= data_d;
            instret_q <= instret_d;
            halted_q  <= halted_d;
            trap_q    <= trap_d;
        end
    end

    // Register file keeps its contents across reset; x0 is never written
    always_ff @(posedge clock) begin
        if (reset && rf_we && (rd != 5'd0)) regs_q[rd] <= rf_wdata;
    end

    assign mem.memReq       = req_c & reset;
    assign mem.memWrite     = wr_c;
    assign mem.memAddress   = {addr_c[31:2], 2'b00};
    assign mem.memWriteData = b_q;

    assign halted       = halted_q;
    assign trap         = trap_q;
    assign instret      = instret_q;
    assign dInstruction = ir_q;
    assign dPC          = pc_q;
    assign dState       = state_q;
endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: memory model with programmable wait
// states and a store scoreboard.
module tb_multicycle_core;
    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam logic [3:0] ST_FETCH = 4'd0, ST_MEM_WRITE = 4'd6, ST_WB_MEM = 4'd8,
                           ST_BRANCH = 4'd9, ST_HALT = 4'd14, ST_TRAP = 4'd15;

    typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  dWatchSel = 5'd0;
    logic        halted, trap;
    logic [31:0] instret, dRegister, dInstruction, dPC;
    logic [3:0]  dState;

    int checks = 0;
    int failures = 0;
    logic tie_ready = 1'b0;
    int wcfg = 0;
    int wait_cnt = 0;
    logic [31:0] code_mem [256];
    logic [31:0] data_mem [256];
    wr_t exp_q[$];
    wr_t obs_q[$];
    logic        prev_wait = 1'b0;
    logic        prev_wr = 1'b0;
    logic [31:0] prev_addr = '0, prev_wd = '0;

    multicycle_core_if mem_bus();

    multicycle_core #(.RESET_PC(RESET_PC), .HALT_ON_ECALL(1'b1), .CHECK_ALIGN(1'b1)) dut (
        .clock(clock), .reset(reset), .mem(mem_bus),
        .halted(halted), .trap(trap), .instret(instret),
        .dWatchSel(dWatchSel), .dRegister(dRegister), .dInstruction(dInstruction),
        .dPC(dPC), .dState(dState)
    );

    always #10 clock = ~clock;

    assign mem_bus.memReady    = tie_ready | (mem_bus.memReq & (wait_cnt >= wcfg));
    assign mem_bus.memReadData = (mem_bus.memAddress[31:12] == 20'h00400)
                               ? code_mem[mem_bus.memAddress[9:2]]
                               : data_mem[mem_bus.memAddress[9:2]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [4:0] idx, input logic [31:0] exp);
        dWatchSel = idx;
        #1;
        chk(tag, dRegister, exp);
    endtask

    // One clock: sample the bus at the falling edge, let the rising edge happen,
    // then apply the memory side effects of any completed transaction.
    task automatic cycle();
        logic req, fire, wr;
        logic [31:0] a, d;
        req  = mem_bus.memReq;
        fire = mem_bus.memReq & mem_bus.memReady;
        wr   = mem_bus.memWrite;
        a    = mem_bus.memAddress;
        d    = mem_bus.memWriteData;
        if (prev_wait && reset) begin
            chk("hold_req", 32'(req), 32'd1);
            chk("hold_addr", a, prev_addr);
            chk("hold_write", 32'(wr), 32'(prev_wr));
            if (wr) chk("hold_wdata", d, prev_wd);
        end
        prev_wait = req & ~fire & reset;
        prev_addr = a;
        prev_wr   = wr;
        prev_wd   = d;
        @(posedge clock);
        @(negedge clock);
        if (fire) begin
            wait_cnt = 0;
            if (wr) begin
                data_mem[a[9:2]] = d;
                obs_q.push_back({a, d});
            end
        end else if (req) begin
            wait_cnt++;
        end else begin
            wait_cnt = 0;
        end
        #1;
    endtask

    task automatic run_until(input logic [3:0] st, input int max_cyc, output int n);
        n = 0;
        while (dState !== st && n < max_cyc) begin
            cycle();
            n++;
        end
        if (dState !== st) chk("timeout_state", 32'(dState), 32'(st));
    endtask

    task automatic restart();
        reset = 1'b0;
        #1;
        cycle();
        cycle();
        reset = 1'b1;
        #1;
    endtask

    initial begin
        int n, n2;
        for (int i = 0; i < 256; i++) code_mem[i] = 32'hFFFF_FFFF;

        // addi x1,x0,5; addi x2,x1,-7; ecall with memReady tied high
        code_mem[0] = 32'h0050_0093;
        code_mem[1] = 32'hFF90_8113;
        code_mem[2] = 32'h0000_0073;
        tie_ready = 1'b1;
        @(negedge clock);
        #1;
        cycle();
        cycle();
        chk("rst_memReq", 32'(mem_bus.memReq), 32'd0);
        chk("rst_state", 32'(dState), 32'(ST_FETCH));
        chk("rst_pc", dPC, RESET_PC);
        chk("rst_ir", dInstruction, 32'h0);
        chk("rst_instret", instret, 32'h0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_trap", 32'(trap), 32'd0);
        reset = 1'b1;
        #1;
        chk("first_req", 32'(mem_bus.memReq), 32'd1);
        chk("first_addr", mem_bus.memAddress, RESET_PC);
        run_until(ST_HALT, 100, n);
        chk("t1_cycles", 32'(n), 32'd10);
        chk("t1_halted", 32'(halted), 32'd1);
        chk("t1_trap", 32'(trap), 32'd0);
        chk("t1_instret", instret, 32'd2);
        chk("t1_pc", dPC, RESET_PC + 32'd12);
        chk_reg("t1_x1", 5'd1, 32'd5);
        chk_reg("t1_x2", 5'd2, 32'hFFFF_FFFE);
        cycle();
        chk("t1_halt_noreq", 32'(mem_bus.memReq), 32'd0);
        chk("t1_halt_stay", 32'(dState), 32'(ST_HALT));

        // sw x1,8(x0); lw x3,8(x0); ecall with three wait cycles per request
        code_mem[0] = 32'h0010_2423;
        code_mem[1] = 32'h0080_2183;
        code_mem[2] = 32'h0000_0073;
        tie_ready = 1'b0;
        wcfg = 3;
        exp_q.push_back({32'd8, 32'd5});
        restart();
        run_until(ST_MEM_WRITE, 100, n);
        chk("t2_st_addr", mem_bus.memAddress, 32'd8);
        chk("t2_st_write", 32'(mem_bus.memWrite), 32'd1);
        chk("t2_st_wdata", mem_bus.memWriteData, 32'd5);
        run_until(ST_FETCH, 100, n2);
        chk("t2_store_cycles", 32'(n + n2), 32'd10);
        chk("t2_st_to_fetch_req", 32'(mem_bus.memReq), 32'd1);
        chk("t2_st_to_fetch_addr", mem_bus.memAddress, RESET_PC + 32'd4);
        run_until(ST_WB_MEM, 100, n);
        run_until(ST_FETCH, 100, n2);
        chk("t2_load_cycles", 32'(n + n2), 32'd11);
        chk_reg("t2_x3", 5'd3, 32'd5);
        run_until(ST_HALT, 100, n);
        chk("t2_ecall_cycles", 32'(n), 32'd5);
        chk("t2_instret", instret, 32'd2);
        chk("sb_count", 32'(obs_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            wr_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            chk("sb_addr", o.addr, e.addr);
            chk("sb_data", o.data, e.data);
        end

        // bne x0,x0,8 (not taken) then beq x0,x0,-4 (taken back to start)
        code_mem[0] = 32'h0000_1463;
        code_mem[1] = 32'hFE00_0EE3;
        wcfg = 0;
        restart();
        run_until(ST_BRANCH, 20, n);
        cycle();
        chk("t3_bne_cycles", 32'(n + 1), 32'd3);
        chk("t3_bne_state", 32'(dState), 32'(ST_FETCH));
        chk("t3_bne_pc", dPC, RESET_PC + 32'd4);
        chk("t3_bne_instret", instret, 32'd1);
        run_until(ST_BRANCH, 20, n);
        cycle();
        chk("t3_beq_cycles", 32'(n + 1), 32'd3);
        chk("t3_beq_pc", dPC, RESET_PC);
        chk("t3_beq_instret", instret, 32'd2);

        // jal x1,16 then jalr x0,3(x1) with a misaligned target
        code_mem[0] = 32'h0100_00EF;
        code_mem[4] = 32'h0030_8067;
        restart();
        cycle();
        cycle();
        cycle();
        chk("t4_jal_state", 32'(dState), 32'(ST_FETCH));
        chk("t4_jal_pc", dPC, 32'h0040_0010);
        chk_reg("t4_jal_x1", 5'd1, 32'h0040_0004);
        run_until(ST_TRAP, 20, n);
        chk("t4_jalr_cycles", 32'(n), 32'd3);
        chk("t4_jalr_trap", 32'(trap), 32'd1);
        chk("t4_jalr_pc", dPC, 32'h0040_0014);
        chk("t4_jalr_instret", instret, 32'd1);
        chk("t4_jalr_halted", 32'(halted), 32'd0);

        // Illegal word, then misaligned lw x4,2(x0); memReady held high in TRAP
        code_mem[0] = 32'hFFFF_FFFF;
        tie_ready = 1'b1;
        restart();
        run_until(ST_TRAP, 20, n);
        chk("t5_ill_cycles", 32'(n), 32'd2);
        cycle();
        cycle();
        chk("t5_ill_trap", 32'(trap), 32'd1);
        chk("t5_ill_state", 32'(dState), 32'(ST_TRAP));
        chk("t5_ill_instret", instret, 32'd0);
        chk("t5_ill_noreq", 32'(mem_bus.memReq), 32'd0);
        code_mem[0] = 32'h0020_2203;
        restart();
        run_until(ST_TRAP, 20, n);
        chk("t5_lw_cycles", 32'(n), 32'd3);
        cycle();
        cycle();
        chk("t5_lw_state", 32'(dState), 32'(ST_TRAP));
        chk("t5_lw_instret", instret, 32'd0);
        chk("t5_lw_noreq", 32'(mem_bus.memReq), 32'd0);

        // Reset asserted while a fetch is waiting, then a clean rerun
        code_mem[0] = 32'h0050_0093;
        code_mem[1] = 32'hFF90_8113;
        code_mem[2] = 32'h0000_0073;
        tie_ready = 1'b0;
        wcfg = 0;
        restart();
        for (int i = 0; i < 4; i++) cycle();
        chk("t6_pre_instret", instret, 32'd1);
        wcfg = 5;
        #1;
        cycle();
        cycle();
        chk("t6_waiting", 32'(dState), 32'(ST_FETCH));
        reset = 1'b0;
        #1;
        chk("t6_rst_req_now", 32'(mem_bus.memReq), 32'd0);
        cycle();
        chk("t6_rst_req", 32'(mem_bus.memReq), 32'd0);
        chk("t6_rst_pc", dPC, RESET_PC);
        chk("t6_rst_instret", instret, 32'd0);
        chk("t6_rst_state", 32'(dState), 32'(ST_FETCH));
        reset = 1'b1;
        wcfg = 0;
        #1;
        run_until(ST_HALT, 100, n);
        chk("t6_cycles", 32'(n), 32'd10);
        chk("t6_instret", instret, 32'd2);
        chk_reg("t6_x2", 5'd2, 32'hFFFF_FFFE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
